// File: rtl/cu_seq_pkg.sv
// Shared types and constants for the 4-bit CU instruction sequencer:
// control-word layout, source/destination encodings and FSM states.
package cu_seq_pkg;

  typedef enum logic {ST_EXEC, ST_OPERAND} state_t;

  // Low two bits of a 1110_00cc jump opcode.
  typedef enum logic [1:0] {
    JC_JMP  = 2'd0,
    JC_JZ   = 2'd1,
    JC_JNZ  = 2'd2,
    JC_DJNZ = 2'd3
  } jcond_t;

  localparam logic [3:0] SRC_ALU   = 4'd0;
  localparam logic [3:0] SRC_PM    = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;
  localparam logic [3:0] SRC_ZERO  = 4'd10;

  localparam logic [2:0] DST_I     = 3'd6;
  localparam logic [2:0] SRC_I     = 3'd6;
  localparam logic [2:0] DST_OREG  = 3'd4;

  localparam logic [8:0] REG_EN_R  = 9'h010;

  typedef struct packed {
    logic [3:0] ir_nibble;
    logic [3:0] source_sel;
    logic [8:0] reg_en;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic       alternate_function;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    ir_nibble:          4'd0,
    source_sel:         SRC_ZERO,
    reg_en:             9'd0,
    i_sel:              1'b0,
    x_sel:              1'b0,
    y_sel:              1'b0,
    alternate_function: 1'b0
  };

  typedef struct packed {
    ctrl_t      ctrl;
    logic       is_jump;
    jcond_t     jcond;
    logic       is_ldlc;
    logic [2:0] lc_val;
  } decode_t;

  // Destination code 4 addresses o_reg (bit 8); bit 4 is reserved for r.
  function automatic logic [8:0] dst_reg_en(input logic [2:0] ddd);
    logic [8:0] en;
    en = '0;
    if (ddd == DST_OREG) en[8] = 1'b1;
    else                 en[ddd] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/cu_instr_decode.sv
// Purely combinational decoder: one instruction byte to a CU control word
// plus the flags the sequencer needs for jumps and loop-counter loads.
module cu_instr_decode
  import cu_seq_pkg::*;
(
  input  logic [7:0] i_instr,
  output decode_t    o_dec
);

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a stale value and infers a latch.
    o_dec.ctrl    = CTRL_IDLE;
    o_dec.is_jump = 1'b0;
    o_dec.jcond   = jcond_t'(i_instr[1:0]);
    o_dec.is_ldlc = 1'b0;
    o_dec.lc_val  = i_instr[2:0];

    casez (i_instr)
      8'b0???_????: begin
        o_dec.ctrl.source_sel = SRC_PM;
        o_dec.ctrl.ir_nibble  = i_instr[3:0];
        o_dec.ctrl.reg_en     = dst_reg_en(i_instr[6:4]);
      end
      8'b10??_????: begin
        o_dec.ctrl.source_sel = {1'b0, i_instr[2:0]};
        o_dec.ctrl.reg_en     = dst_reg_en(i_instr[5:3]);
        o_dec.ctrl.i_sel      = (i_instr[5:3] == DST_I) && (i_instr[2:0] == SRC_I);
      end
      8'b110?_????: begin
        o_dec.ctrl.source_sel = SRC_ALU;
        o_dec.ctrl.ir_nibble  = {1'b0, i_instr[2:0]};
        o_dec.ctrl.x_sel      = i_instr[4];
        o_dec.ctrl.y_sel      = i_instr[3];
        o_dec.ctrl.reg_en     = REG_EN_R;
      end
      8'b1111_0???: begin
        o_dec.ctrl.alternate_function = 1'b1;
        o_dec.ctrl.ir_nibble  = {3'b000, i_instr[0]};
        o_dec.ctrl.x_sel      = i_instr[2];
        o_dec.ctrl.y_sel      = i_instr[1];
        o_dec.ctrl.reg_en     = REG_EN_R;
      end
      8'b1111_1???: begin
        o_dec.ctrl.source_sel = SRC_IPINS;
        o_dec.ctrl.reg_en     = dst_reg_en(i_instr[2:0]);
      end
      // 1110_01xx are NOPs: idle control word, single cycle.
      8'b1110_0???: o_dec.is_jump = ~i_instr[2];
      8'b1110_1???: o_dec.is_ldlc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cu_instruction_sequencer.sv
// Program sequencer for the 4-bit CU: holds pc, loop counter and the
// EXEC/OPERAND FSM; control outputs are combinational from pm_data and state.
module cu_instruction_sequencer
  import cu_seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int LC_W = 4
) (
  input  logic            clk,
  input  logic            sync_reset,
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  output logic [PC_W-1:0] pm_address,
  output logic [3:0]      ir_nibble,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic            alternate_function,
  output logic [LC_W-1:0] lc
);

  state_t          r_state;
  jcond_t          r_jcond;
  logic [PC_W-1:0] r_pc;
  logic [LC_W-1:0] r_lc;

  decode_t         w_dec;
  ctrl_t           w_ctrl;
  logic            w_taken;
  logic [PC_W-1:0] w_pc_inc;

  cu_instr_decode u_decode (
    .i_instr (pm_data),
    .o_dec   (w_dec)
  );

  assign w_pc_inc = r_pc + PC_W'(1);

  // DJNZ jumps only when the decremented count is still non-zero.
  always_comb begin
    w_taken = 1'b0;
    case (r_jcond)
      JC_JMP:  w_taken = 1'b1;
      JC_JZ:   w_taken = r_eq_0;
      JC_JNZ:  w_taken = ~r_eq_0;
      JC_DJNZ: w_taken = (r_lc > LC_W'(1));
      default: w_taken = 1'b0;
    endcase
  end

  // While in reset, pulse r's write enable so the CU clears r and sets r_eq_0.
  always_comb begin
    w_ctrl = w_dec.ctrl;
    if (sync_reset) begin
      w_ctrl        = CTRL_IDLE;
      w_ctrl.reg_en = REG_EN_R;
    end else if (r_state == ST_OPERAND) begin
      w_ctrl = CTRL_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state <= ST_EXEC;
      r_jcond <= JC_JMP;
      r_pc    <= '0;
      r_lc    <= '0;
    end else begin
      case (r_state)
        ST_EXEC: begin
          r_pc <= w_pc_inc;
          if (w_dec.is_jump) begin
            r_state <= ST_OPERAND;
            r_jcond <= w_dec.jcond;
          end
          if (w_dec.is_ldlc) r_lc <= LC_W'(w_dec.lc_val);
        end
        ST_OPERAND: begin
          r_state <= ST_EXEC;
          r_pc    <= w_taken ? PC_W'(pm_data) : w_pc_inc;
          if (r_jcond == JC_DJNZ && r_lc != '0) r_lc <= r_lc - LC_W'(1);
        end
        default: r_state <= ST_EXEC;
      endcase
    end
  end

  assign pm_address         = r_pc;
  assign lc                 = r_lc;
  assign ir_nibble          = w_ctrl.ir_nibble;
  assign source_sel         = w_ctrl.source_sel;
  assign reg_en             = w_ctrl.reg_en;
  assign i_sel              = w_ctrl.i_sel;
  assign x_sel              = w_ctrl.x_sel;
  assign y_sel              = w_ctrl.y_sel;
  assign alternate_function = w_ctrl.alternate_function;

endmodule
